bp_l15_responder: RTL and testbench

Responder for the L1.5 transducer request interface. Accepts the requests a BP-side transducer issues toward the L1.5 (load, instruction fill, store), services them against an internal 64-bit-word backing memory after a configurable latency, and returns L1.5-style responses. It serves as the L1.5 end of the link in standalone transducer benches and in reduced tiles without a full L1.5/L2.

---
 rtl/bp_l15_pkg.sv | 52 +++++
 rtl/bp_l15_responder_mem.sv | 40 ++++
 rtl/bp_l15_responder.sv | 205 ++++++++++++++++++++
 tb/tb_bp_l15_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_l15_pkg.sv
// Shared definitions for the L1.5 transducer responder: request/return
// type codes, access size encoding, FSM states and byte-lane helpers.
package bp_l15_pkg;

   localparam logic [4:0] LOAD_RQ  = 5'b00000;
   localparam logic [4:0] IMISS_RQ = 5'b10000;
   localparam logic [4:0] STORE_RQ = 5'b00001;

   localparam logic [3:0] LOAD_RET  = 4'b0000;
   localparam logic [3:0] IFILL_RET = 4'b0001;
   localparam logic [3:0] ST_ACK    = 4'b0100;
   localparam logic [3:0] ERR_RET   = 4'b1111;

   typedef enum logic [2:0] {
      SIZE_1B = 3'd0,
      SIZE_2B = 3'd1,
      SIZE_4B = 3'd2,
      SIZE_8B = 3'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   // Byte lanes touched by an access of 2**size bytes starting at offset
   function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

   // Low address bits that must be zero for an access of 2**size bytes
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [2:0] m;
      case (size)
         2'd0:    m = 3'b000;
         2'd1:    m = 3'b001;
         2'd2:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bp_l15_responder_mem.sv
// Backing store for the responder: 64-bit words, a two-word block read
// port (even/odd pair, combinational) and a byte-masked synchronous write.
// Contents are deliberately not reset.
module bp_l15_responder_mem
   import bp_l15_pkg::*;
#(
   parameter  int unsigned words_p  = 1024,
   localparam int unsigned idx_w_lp = $clog2(words_p)
) (
   input  logic                clk_i,
   input  logic [idx_w_lp-1:0] rd_idx_i,
   output logic [63:0]         rd_data_0_o,
   output logic [63:0]         rd_data_1_o,
   input  logic                wr_en_i,
   input  logic [idx_w_lp-1:0] wr_idx_i,
   input  logic [7:0]          wr_mask_i,
   input  logic [63:0]         wr_data_i
);

   logic [63:0]         mem_q [words_p];
   logic [idx_w_lp-1:0] even_idx;
   logic [idx_w_lp-1:0] odd_idx;

   assign even_idx    = rd_idx_i & ~idx_w_lp'(1);
   assign odd_idx     = even_idx | idx_w_lp'(1);
   assign rd_data_0_o = mem_q[even_idx];
   assign rd_data_1_o = mem_q[odd_idx];

   // Byte-masked word write; only enabled lanes change
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int b = 0; b < 8; b++) begin
            if (wr_mask_i[b]) begin
               mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/bp_l15_responder.sv
// L1.5 end of the transducer link: acknowledges one request at a time,
// services it against a local memory after latency_p cycles and holds the
// response until the initiator consumes it.
// Optional macro L15_RESPONDER_STALL_EN adds LFSR-driven idle stalls
// before a request is captured.
module bp_l15_responder
   import bp_l15_pkg::*;
#(
   parameter int unsigned paddr_width_p = 40,
   parameter int unsigned mem_words_p   = 1024,
   parameter int unsigned latency_p     = 4,
   parameter logic [15:0] lfsr_seed_p   = 16'hACE1
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     transducer_l15_val,
   input  logic [4:0]               transducer_l15_rqtype,
   input  logic [2:0]               transducer_l15_size,
   input  logic [paddr_width_p-1:0] transducer_l15_address,
   input  logic [63:0]              transducer_l15_data,
   input  logic                     transducer_l15_nc,
   output logic                     l15_transducer_header_ack,
   output logic                     l15_transducer_ack,
   output logic                     l15_transducer_val,
   output logic [3:0]               l15_transducer_returntype,
   output logic [63:0]              l15_transducer_data_0,
   output logic [63:0]              l15_transducer_data_1,
   input  logic                     transducer_l15_req_ack
);

   localparam int unsigned IW       = $clog2(mem_words_p);
   localparam int unsigned CW       = (latency_p > 1) ? $clog2(latency_p) : 1;
   localparam int unsigned LOAD_CNT = (latency_p > 0) ? latency_p - 1 : 0;

   state_e                   state_q, state_d;
   logic [4:0]               rqtype_q, rqtype_d;
   logic [2:0]               size_q, size_d;
   logic [paddr_width_p-1:0] addr_q, addr_d;
   logic [63:0]              wdata_q, wdata_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     ack_q, ack_d;
   logic                     val_q, val_d;
   logic [3:0]               rtype_q, rtype_d;
   logic [63:0]              data0_q, data0_d;
   logic [63:0]              data1_q, data1_d;

   logic                     is_load, is_store, req_err, access, mem_we, can_capture;
   logic [IW-1:0]            word_idx;
   logic [63:0]              rd_data_0, rd_data_1;
   logic                     unused_bits;

`ifdef L15_RESPONDER_STALL_EN
   logic [15:0]              lfsr_q, lfsr_d;
   logic [1:0]               stall_q, stall_d;
`endif

   assign word_idx    = addr_q[3 +: IW];
   assign unused_bits = ^{transducer_l15_nc, addr_q};

   // Classify the captured request and decide whether it is serviceable
   always_comb begin
      is_load  = (rqtype_q == LOAD_RQ) || (rqtype_q == IMISS_RQ);
      is_store = (rqtype_q == STORE_RQ);
      req_err  = !(is_load || is_store);
      if (is_store && ((size_q > SIZE_8B) || ((addr_q[2:0] & align_mask(size_q[1:0])) != 3'b000))) begin
         req_err = 1'b1;
      end
      access = ((state_q == ACK) && (latency_p == 0)) || ((state_q == WAIT) && (cnt_q == '0));
      mem_we = access && is_store && !req_err;
   end

   // Next-state and registered-output logic for the request handshake
   always_comb begin
      state_d  = state_q;
      rqtype_d = rqtype_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      val_d    = val_q;
      rtype_d  = rtype_q;
      data0_d  = data0_q;
      data1_d  = data1_q;
`ifdef L15_RESPONDER_STALL_EN
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      stall_d     = stall_q;
      can_capture = (stall_q == 2'd0);
      if ((state_q == IDLE) && (stall_q != 2'd0)) begin
         stall_d = stall_q - 2'd1;
      end
`else
      can_capture = 1'b1;
`endif
      case (state_q)
         IDLE: begin
            if (can_capture && transducer_l15_val) begin
               rqtype_d = transducer_l15_rqtype;
               size_d   = transducer_l15_size;
               addr_d   = transducer_l15_address;
               wdata_d  = transducer_l15_data;
               ack_d    = 1'b1;
               state_d  = ACK;
            end
         end
         ACK: begin
            if (latency_p > 0) begin
               cnt_d   = CW'(LOAD_CNT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (transducer_l15_req_ack) begin
               val_d   = 1'b0;
               rtype_d = 4'b0000;
               data0_d = '0;
               data1_d = '0;
               state_d = IDLE;
`ifdef L15_RESPONDER_STALL_EN
               stall_d = lfsr_q[1:0];
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      if (access) begin
         state_d = RESP;
         val_d   = 1'b1;
         data0_d = '0;
         data1_d = '0;
         if (req_err) begin
            rtype_d = ERR_RET;
         end else if (is_store) begin
            rtype_d = ST_ACK;
         end else begin
            rtype_d = (rqtype_q == IMISS_RQ) ? IFILL_RET : LOAD_RET;
            data0_d = rd_data_0;
            data1_d = rd_data_1;
         end
      end
   end

   // State, captured request and response registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         rqtype_q <= '0;
         size_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         val_q    <= 1'b0;
         rtype_q  <= '0;
         data0_q  <= '0;
         data1_q  <= '0;
`ifdef L15_RESPONDER_STALL_EN
         lfsr_q   <= lfsr_seed_p;
         stall_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rqtype_q <= rqtype_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         val_q    <= val_d;
         rtype_q  <= rtype_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
`ifdef L15_RESPONDER_STALL_EN
         lfsr_q   <= lfsr_d;
         stall_q  <= stall_d;
`endif
      end
   end

   bp_l15_responder_mem #(
      .words_p (mem_words_p)
   ) u_mem (
      .clk_i       (clk_i),
      .rd_idx_i    (word_idx),
      .rd_data_0_o (rd_data_0),
      .rd_data_1_o (rd_data_1),
      .wr_en_i     (mem_we),
      .wr_idx_i    (word_idx),
      .wr_mask_i   (byte_mask(size_q[1:0], addr_q[2:0])),
      .wr_data_i   (wdata_q)
   );

   assign l15_transducer_header_ack = ack_q;
   assign l15_transducer_ack        = ack_q;
   assign l15_transducer_val        = val_q;
   assign l15_transducer_returntype = rtype_q;
   assign l15_transducer_data_0     = data0_q;
   assign l15_transducer_data_1     = data1_q;

endmodule

// File: tb/tb_bp_l15_responder.sv
// Directed bench for bp_l15_responder: one instance at latency 4 and one at
// latency 0, selected through a shared request bus.
module tb_bp_l15_responder;
   import bp_l15_pkg::*;

   logic        clock;
   logic        resetN;
   logic        sel;
   logic        reqVal;
   logic [4:0]  reqType;
   logic [2:0]  reqSize;
   logic [39:0] reqAddr;
   logic [63:0] reqData;
   logic        reqAck;

   logic        hdr4, ack4, val4, hdr0, ack0, val0;
   logic [3:0]  rt4, rt0;
   logic [63:0] d04, d14, d00, d10;

   logic        obsHdr, obsAck, obsVal;
   logic [3:0]  obsRt;
   logic [63:0] obsD0, obsD1;

   int compared;
   int mismatched;

   assign obsHdr = sel ? hdr0 : hdr4;
   assign obsAck = sel ? ack0 : ack4;
   assign obsVal = sel ? val0 : val4;
   assign obsRt  = sel ? rt0  : rt4;
   assign obsD0  = sel ? d00  : d04;
   assign obsD1  = sel ? d10  : d14;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   bp_l15_responder #(.latency_p(4)) dut (
      .clk_i                     (clock),
      .reset_n_i                 (resetN),
      .transducer_l15_val        (reqVal & ~sel),
      .transducer_l15_rqtype     (reqType),
      .transducer_l15_size       (reqSize),
      .transducer_l15_address    (reqAddr),
      .transducer_l15_data       (reqData),
      .transducer_l15_nc         (1'b0),
      .l15_transducer_header_ack (hdr4),
      .l15_transducer_ack        (ack4),
      .l15_transducer_val        (val4),
      .l15_transducer_returntype (rt4),
      .l15_transducer_data_0     (d04),
      .l15_transducer_data_1     (d14),
      .transducer_l15_req_ack    (reqAck & ~sel)
   );

   bp_l15_responder #(.latency_p(0)) dutFast (
      .clk_i                     (clock),
      .reset_n_i                 (resetN),
      .transducer_l15_val        (reqVal & sel),
      .transducer_l15_rqtype     (reqType),
      .transducer_l15_size       (reqSize),
      .transducer_l15_address    (reqAddr),
      .transducer_l15_data       (reqData),
      .transducer_l15_nc         (1'b1),
      .l15_transducer_header_ack (hdr0),
      .l15_transducer_ack        (ack0),
      .l15_transducer_val        (val0),
      .l15_transducer_returntype (rt0),
      .l15_transducer_data_0     (d00),
      .l15_transducer_data_1     (d10),
      .transducer_l15_req_ack    (reqAck & sel)
   );

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   // Issue one request, verify handshake timing, capture and consume the response
   task automatic applyStimulus(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] addr,
                                input logic [63:0] dat, input int expLat,
                                output logic [3:0] rt, output logic [63:0] d0, output logic [63:0] d1);
      int n;
      @(negedge clock);
      reqType = rq; reqSize = sz; reqAddr = addr; reqData = dat; reqVal = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!obsAck && n < 30);
      checkOutput("ack delay", 64'(n), 64'd1);
      checkOutput("header_ack with ack", {63'd0, obsHdr}, 64'd1);
      reqVal = 1'b0;
      n = 0;
      while (!obsVal && n < 40) begin
         @(negedge clock);
         n++;
      end
      checkOutput("val delay after ack", 64'(n), 64'(expLat + 1));
      rt = obsRt; d0 = obsD0; d1 = obsD1;
      reqAck = 1'b1;
      @(negedge clock);
      reqAck = 1'b0;
      checkOutput("val drop after req_ack", {63'd0, obsVal}, 64'd0);
   endtask

   localparam logic [63:0] WORD_108 = 64'h0F0E_0D0C_0B0A_0908;
   localparam logic [63:0] WORD_100 = 64'h1122_3344_5566_7788;
   localparam logic [63:0] WORD_100B = 64'h1122_3344_AB66_7788;

   initial begin
      logic [3:0]  rt;
      logic [63:0] d0, d1;
      int          n;
      int          extraAcks;
      compared = 0; mismatched = 0;
      sel = 1'b0; reqVal = 1'b0; reqAck = 1'b0;
      reqType = '0; reqSize = '0; reqAddr = '0; reqData = '0;
      resetN = 1'b0;

      @(negedge clock);
      checkOutput("reset ack", {63'd0, obsAck}, 64'd0);
      checkOutput("reset header_ack", {63'd0, obsHdr}, 64'd0);
      checkOutput("reset val", {63'd0, obsVal}, 64'd0);
      checkOutput("reset returntype", {60'd0, obsRt}, 64'd0);
      checkOutput("reset data_0", obsD0, 64'd0);
      checkOutput("reset data_1", obsD1, 64'd0);
      resetN = 1'b1;

      applyStimulus(STORE_RQ, 3'd3, 40'h108, WORD_108, 4, rt, d0, d1);
      checkOutput("store 0x108 rt", {60'd0, rt}, {60'd0, ST_ACK});
      applyStimulus(STORE_RQ, 3'd3, 40'h100, WORD_100, 4, rt, d0, d1);
      checkOutput("store 0x100 rt", {60'd0, rt}, {60'd0, ST_ACK});
      checkOutput("store d0 zero", d0, 64'd0);
      checkOutput("store d1 zero", d1, 64'd0);

      applyStimulus(LOAD_RQ, 3'd3, 40'h100, 64'd0, 4, rt, d0, d1);
      checkOutput("load rt", {60'd0, rt}, {60'd0, LOAD_RET});
      checkOutput("load d0", d0, WORD_100);
      checkOutput("load d1", d1, WORD_108);

      applyStimulus(IMISS_RQ, 3'd3, 40'h108, 64'd0, 4, rt, d0, d1);
      checkOutput("ifill rt", {60'd0, rt}, {60'd0, IFILL_RET});
      checkOutput("ifill d0", d0, WORD_100);
      checkOutput("ifill d1", d1, WORD_108);

      applyStimulus(STORE_RQ, 3'd0, 40'h103, 64'hFFFF_FFFF_ABFF_FFFF, 4, rt, d0, d1);
      checkOutput("byte store rt", {60'd0, rt}, {60'd0, ST_ACK});
      applyStimulus(LOAD_RQ, 3'd0, 40'h100, 64'd0, 4, rt, d0, d1);
      checkOutput("byte store d0", d0, WORD_100B);
      checkOutput("byte store d1", d1, WORD_108);

      applyStimulus(STORE_RQ, 3'd2, 40'h102, 64'hFFFF_FFFF_FFFF_FFFF, 4, rt, d0, d1);
      checkOutput("misaligned rt", {60'd0, rt}, {60'd0, ERR_RET});
      checkOutput("misaligned d0", d0, 64'd0);
      applyStimulus(STORE_RQ, 3'd4, 40'h100, 64'hFFFF_FFFF_FFFF_FFFF, 4, rt, d0, d1);
      checkOutput("bad size rt", {60'd0, rt}, {60'd0, ERR_RET});
      applyStimulus(5'b00111, 3'd3, 40'h100, 64'hFFFF_FFFF_FFFF_FFFF, 4, rt, d0, d1);
      checkOutput("bad rqtype rt", {60'd0, rt}, {60'd0, ERR_RET});
      checkOutput("bad rqtype d1", d1, 64'd0);
      applyStimulus(LOAD_RQ, 3'd3, 40'h100, 64'd0, 4, rt, d0, d1);
      checkOutput("after errors d0", d0, WORD_100B);
      checkOutput("after errors d1", d1, WORD_108);

      // Response held for 5 cycles while a second request waits
      @(negedge clock);
      reqType = LOAD_RQ; reqSize = 3'd3; reqAddr = 40'h100; reqVal = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!obsAck && n < 30);
      reqVal = 1'b0;
      n = 0;
      while (!obsVal && n < 40) begin @(negedge clock); n++; end
      checkOutput("hold first d0", obsD0, WORD_100B);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i == 1) begin
            reqType = IMISS_RQ; reqAddr = 40'h108; reqVal = 1'b1;
         end
         checkOutput("hold val", {63'd0, obsVal}, 64'd1);
         checkOutput("hold d0", obsD0, WORD_100B);
         checkOutput("hold no ack", {63'd0, obsAck}, 64'd0);
      end
      reqAck = 1'b1;
      @(negedge clock);
      reqAck = 1'b0;
      checkOutput("consumed val", {63'd0, obsVal}, 64'd0);
      checkOutput("no ack in idle cycle", {63'd0, obsAck}, 64'd0);
      @(negedge clock);
      checkOutput("queued request ack", {63'd0, obsAck}, 64'd1);
      reqVal = 1'b0;
      n = 0;
      while (!obsVal && n < 40) begin @(negedge clock); n++; end
      checkOutput("queued rt", {60'd0, obsRt}, {60'd0, IFILL_RET});
      reqAck = 1'b1;
      @(negedge clock);
      reqAck = 1'b0;
      extraAcks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (obsAck) extraAcks++;
      end
      checkOutput("no double capture", 64'(extraAcks), 64'd0);

      // Reset during WAIT of a store must drop the write
      @(negedge clock);
      reqType = STORE_RQ; reqSize = 3'd3; reqAddr = 40'h100; reqData = 64'hDEAD_BEEF_CAFE_F00D; reqVal = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!obsAck && n < 30);
      reqVal = 1'b0;
      @(negedge clock);
      resetN = 1'b0;
      #1;
      checkOutput("mid reset val", {63'd0, obsVal}, 64'd0);
      checkOutput("mid reset ack", {63'd0, obsAck}, 64'd0);
      checkOutput("mid reset rt", {60'd0, obsRt}, 64'd0);
      @(negedge clock);
      resetN = 1'b1;
      applyStimulus(LOAD_RQ, 3'd3, 40'h100, 64'd0, 4, rt, d0, d1);
      checkOutput("post reset d0", d0, WORD_100B);
      checkOutput("post reset rt", {60'd0, rt}, {60'd0, LOAD_RET});

      // Zero-latency instance
      sel = 1'b1;
      applyStimulus(STORE_RQ, 3'd3, 40'h200, 64'h5555_AAAA_1234_5678, 0, rt, d0, d1);
      checkOutput("lat0 store rt", {60'd0, rt}, {60'd0, ST_ACK});
      applyStimulus(LOAD_RQ, 3'd3, 40'h208, 64'd0, 0, rt, d0, d1);
      checkOutput("lat0 load rt", {60'd0, rt}, {60'd0, LOAD_RET});
      checkOutput("lat0 load d0", d0, 64'h5555_AAAA_1234_5678);
      sel = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
